// File: rtl/rxe_pktpack.sv
// Receive packetiser: packs PHY bytes MSB-first into DW-bit beats, queues them in
// a packet FIFO and drives an AXIN master stream with BYTES, LAST and ABORT.
module rxe_pktpack #(
    parameter int DW     = 32,
    parameter int LGFIFO = 4,
    parameter int LENW   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_abort,
    input  logic                      i_v,
    input  logic [7:0]                i_d,
    input  logic                      i_not_done,
    output logic                      M_AXIN_VALID,
    input  logic                      M_AXIN_READY,
    output logic [DW-1:0]             M_AXIN_DATA,
    output logic [$clog2(DW/8):0]     M_AXIN_BYTES,
    output logic                      M_AXIN_LAST,
    output logic                      M_AXIN_ABORT,
    output logic                      o_pkt_stb,
    output logic [LENW-1:0]           o_pkt_len
);
    localparam int NB    = DW / 8;
    localparam int BW    = $clog2(NB) + 1;
    localparam int DEPTH = 1 << LGFIFO;
    localparam int EW    = DW + BW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DROP} state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     stage;
    logic [BW-1:0]     scnt;
    logic [LENW-1:0]   count;
    logic [LGFIFO:0]   wr_ptr, rd_ptr, start_ptr, fifo_lasts;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     rd_entry;
    logic              out_mid;

    logic fifo_empty, fifo_full, hs;
    logic push_req, push_last, byte_ok, len_ovf;
    logic pop_raw, overflow, abort_ev, push, pop, take_byte, emitted, cur_in_out;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                        (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
    assign rd_entry   = mem[rd_ptr[LGFIFO-1:0]];
    assign hs         = M_AXIN_VALID && M_AXIN_READY;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        push_last = 1'b0;
        byte_ok   = 1'b0;
        len_ovf   = 1'b0;
        case (state)
            S_IDLE: if (i_v) begin
                state_nxt = S_RUN;
                byte_ok   = 1'b1;
            end
            S_RUN: if (i_v) begin
                byte_ok  = 1'b1;
                len_ovf  = &count;
                push_req = (scnt == BW'(NB));
            end else begin
                push_req  = 1'b1;
                push_last = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DROP: if (!i_v && !i_not_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        pop_raw   = !fifo_empty && (!M_AXIN_VALID || M_AXIN_READY);
        overflow  = push_req && fifo_full && !pop_raw;
        abort_ev  = (state == S_RUN) && (i_abort || overflow || len_ovf);
        if (abort_ev) state_nxt = S_DROP;
        // An abort freezes the read side for a cycle so the pointer rewind is exact.
        push      = push_req && !abort_ev;
        pop       = pop_raw && !abort_ev;
        take_byte = byte_ok && !abort_ev;
        // With no LAST queued, anything in or past the output register is this packet.
        emitted    = out_mid || (hs && !M_AXIN_LAST);
        cur_in_out = (fifo_lasts == '0) && (M_AXIN_VALID ? !M_AXIN_LAST : out_mid);
    end

    // NOTE: the storage array has no reset; the pointers alone define valid entries.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[LGFIFO-1:0]] <= {stage, scnt, push_last};
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees the old value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            stage        <= '0;
            scnt         <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            start_ptr    <= '0;
            fifo_lasts   <= '0;
            out_mid      <= 1'b0;
            M_AXIN_VALID <= 1'b0;
            M_AXIN_DATA  <= '0;
            M_AXIN_BYTES <= '0;
            M_AXIN_LAST  <= 1'b0;
            M_AXIN_ABORT <= 1'b0;
            o_pkt_stb    <= 1'b0;
            o_pkt_len    <= '0;
        end else begin
            state        <= state_nxt;
            o_pkt_stb    <= 1'b0;
            M_AXIN_ABORT <= 1'b0;

            if (take_byte) begin
                count <= count + 1'b1;
                if (scnt == '0 || scnt == BW'(NB)) begin
                    stage <= {i_d, {(DW-8){1'b0}}};
                    scnt  <= BW'(1);
                end else begin
                    for (int k = 1; k < NB; k++)
                        if (scnt == BW'(k)) stage[DW-1-8*k -: 8] <= i_d;
                    scnt <= scnt + 1'b1;
                end
            end
            if (state_nxt != S_RUN) begin
                scnt  <= '0;
                count <= '0;
            end
            if (state == S_IDLE && i_v) start_ptr <= wr_ptr;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (push && push_last) begin
                o_pkt_stb <= 1'b1;
                o_pkt_len <= count;
            end
            case ({push && push_last, pop && rd_entry[0]})
                2'b10:   fifo_lasts <= fifo_lasts + 1'b1;
                2'b01:   fifo_lasts <= fifo_lasts - 1'b1;
                default: fifo_lasts <= fifo_lasts;
            endcase

            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                M_AXIN_VALID <= 1'b1;
                {M_AXIN_DATA, M_AXIN_BYTES, M_AXIN_LAST} <= rd_entry;
            end else if (M_AXIN_READY) begin
                M_AXIN_VALID <= 1'b0;
            end
            if (hs) out_mid <= !M_AXIN_LAST;

            if (abort_ev) begin
                if (cur_in_out) begin
                    wr_ptr       <= rd_ptr;
                    M_AXIN_VALID <= 1'b0;
                    M_AXIN_ABORT <= emitted;
                    out_mid      <= 1'b0;
                end else begin
                    wr_ptr <= start_ptr;
                end
            end
        end
    end

endmodule
